// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data width, fetch FSM state encoding and the
// buffered fetch entry layout.
package cpu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } fq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer storage: circular FIFO of fetch entries with flush,
// occupancy count and full/empty flags. Head is zero whenever empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word fetches under a credit limit, buffers
// responses for the decoder and restarts on redirect. Optional macro
// FETCH_QUEUE_ALIGN_CHECK_EN enables the sticky misaligned-redirect flag.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err,
    output fq_state_e       dbg_state
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

    fq_state_e       state;
    fq_state_e       state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc_q;
    logic            outstanding;
    logic [CW-1:0]   occupancy;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            credit_ok;
    logic            issue;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] target;

    assign target = word_align(redirect_pc);

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign credit_ok = (({1'b0, occupancy} + {{CW{1'b0}}, outstanding}) < DEPTH_L) && !fifo_full;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                issue = credit_ok && !redirect;
                // A request sent before the redirect may still be answered.
                if (redirect && outstanding) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                issue      = credit_ok && !redirect;
                state_next = RUN;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            req_pc_q    <= '0;
            outstanding <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= issue;
            if (issue) begin
                req_pc_q <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= target;
            end else if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc;
    assign dbg_state = state;

    // Decoder handshake: inst_valid means the head entry is presented and holds
    // stable until taken; the entry leaves on any cycle with inst_valid && inst_ready,
    // except a redirect cycle, which flushes the buffer instead.
    assign push = imem_rvalid && (state == RUN) && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    assign push_entry.pc   = req_pc_q;
    assign push_entry.inst = imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid = !fifo_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule
